// File: rtl/sq_deq_ctrl.sv
// sq_deq_ctrl -- in-order store queue dequeue controller.
//
// Watches the entry at the head of the store queue. Once that entry is valid
// and committed, its payload is latched. It is then sent either to the dcache
// or to the MMIO bus, depending on the entry's MMIO flag. The controller
// waits for the completion, gives a one-cycle release pulse to the entry and
// moves the head pointer forward. Only one store is outstanding at a time.
//
// Ports
//   clock, reset_n            clock (rising edge), async active-low reset
//   flush                     pipeline flush: head_ptr returns to 0 and the
//                             in-flight store is abandoned; if the store was
//                             already accepted, the controller drains its
//                             response first
//   entry_ready_vec           per-entry valid & committed
//   entry_mmio_vec            per-entry MMIO flag
//   head_addr/data/mask       payload of the entry at the head index
//   head_ls_size              access size of the entry at the head index
//   head_ptr                  oldest-entry pointer, MSB is the wrap bit
//   issuing_vec               one-hot release pulse to the head entry
//   dc_req_* / dc_resp_valid  dcache store request / completion
//   mmio_req_* / mmio_resp_*  MMIO bus request / completion
//   busy                      controller is not idle
module sq_deq_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] entry_ready_vec,
  input  logic [DEPTH-1:0] entry_mmio_vec,
  input  logic [63:0]      head_addr,
  input  logic [63:0]      head_data,
  input  logic [63:0]      head_mask,
  input  logic [3:0]       head_ls_size,
  output logic [PTR_W:0]   head_ptr,
  output logic [DEPTH-1:0] issuing_vec,
  output logic             dc_req_valid,
  input  logic             dc_req_ready,
  output logic [63:0]      dc_req_addr,
  output logic [63:0]      dc_req_data,
  output logic [63:0]      dc_req_mask,
  output logic [3:0]       dc_req_size,
  input  logic             dc_resp_valid,
  output logic             mmio_req_valid,
  input  logic             mmio_req_ready,
  input  logic             mmio_resp_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    DC_REQ,
    DC_WAIT,
    MMIO_REQ,
    MMIO_WAIT,
    DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W:0]   head_reg, head_next;
  logic [63:0]      addr_reg, data_reg, mask_reg;
  logic [3:0]       size_reg;
  // Kind of the store in flight. DRAIN uses it to know which response to wait for.
  logic             mmio_reg;
  logic             capture;
  logic             release_head;
  logic             drain_resp;
  logic [PTR_W-1:0] head_idx;

  assign head_idx   = head_reg[PTR_W-1:0];
  assign drain_resp = mmio_reg ? mmio_resp_valid : dc_resp_valid;

  always_comb begin
    state_next     = state_reg;
    head_next      = head_reg;
    capture        = 1'b0;
    release_head   = 1'b0;
    dc_req_valid   = 1'b0;
    mmio_req_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          head_next = '0;
        end else if (entry_ready_vec[head_idx]) begin
          capture    = 1'b1;
          state_next = entry_mmio_vec[head_idx] ? MMIO_REQ : DC_REQ;
        end
      end
      DC_REQ: begin
        dc_req_valid = 1'b1;
        if (flush) begin
          // If the request is accepted on the flush cycle, a response is
          // still coming and must be drained.
          head_next  = '0;
          state_next = dc_req_ready ? DRAIN : IDLE;
        end else if (dc_req_ready) begin
          state_next = DC_WAIT;
        end
      end
      MMIO_REQ: begin
        mmio_req_valid = 1'b1;
        if (flush) begin
          head_next  = '0;
          state_next = mmio_req_ready ? DRAIN : IDLE;
        end else if (mmio_req_ready) begin
          state_next = MMIO_WAIT;
        end
      end
      DC_WAIT: begin
        if (flush) begin
          // A response on the flush cycle completes the drain at once.
          head_next  = '0;
          state_next = dc_resp_valid ? IDLE : DRAIN;
        end else if (dc_resp_valid) begin
          release_head = 1'b1;
          head_next    = head_reg + {{PTR_W{1'b0}}, 1'b1};
          state_next   = IDLE;
        end
      end
      MMIO_WAIT: begin
        if (flush) begin
          head_next  = '0;
          state_next = mmio_resp_valid ? IDLE : DRAIN;
        end else if (mmio_resp_valid) begin
          release_head = 1'b1;
          head_next    = head_reg + {{PTR_W{1'b0}}, 1'b1};
          state_next   = IDLE;
        end
      end
      DRAIN: begin
        // head_ptr is already 0 here, so a repeated flush changes nothing.
        if (drain_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      head_reg  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
      size_reg  <= '0;
      mmio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      if (capture) begin
        addr_reg <= head_addr;
        data_reg <= head_data;
        mask_reg <= head_mask;
        size_reg <= head_ls_size;
        mmio_reg <= entry_mmio_vec[head_idx];
      end
    end
  end

  // Release pulse decode. release_head is only raised when flush is low.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_issue
    assign issuing_vec[gi] = release_head && (head_idx == PTR_W'(gi));
  end

  assign head_ptr    = head_reg;
  assign dc_req_addr = addr_reg;
  assign dc_req_data = data_reg;
  assign dc_req_mask = mask_reg;
  assign dc_req_size = size_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_sq_deq_ctrl.sv
// tb_sq_deq_ctrl -- self-checking bench for sq_deq_ctrl.
// A scoreboard queue holds the expected store payloads. Each entry is pushed
// when the bench makes a head entry ready. It is popped and compared when the
// DUT completes the request handshake. The bench keeps its own head pointer
// model. Store modes: 0 normal, 1 flush in WAIT, 2 flush with the response,
// 3 flush in REQ before the handshake, 4 flush with the handshake, 5 reset in REQ.
module tb_sq_deq_ctrl;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] mask;
    logic [3:0]  size;
    logic        mmio;
    int          idx;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [DEPTH-1:0] entry_ready_vec = '0;
  logic [DEPTH-1:0] entry_mmio_vec = '0;
  logic [63:0]      head_addr, head_data, head_mask;
  logic [3:0]       head_ls_size;
  logic [PTR_W:0]   head_ptr;
  logic [DEPTH-1:0] issuing_vec;
  logic             dc_req_valid;
  logic             dc_req_ready = 1'b0;
  logic [63:0]      dc_req_addr, dc_req_data, dc_req_mask;
  logic [3:0]       dc_req_size;
  logic             dc_resp_valid = 1'b0;
  logic             mmio_req_valid;
  logic             mmio_req_ready = 1'b0;
  logic             mmio_resp_valid = 1'b0;
  logic             busy;

  logic [63:0] ent_addr [DEPTH];
  logic [63:0] ent_data [DEPTH];
  logic [63:0] ent_mask [DEPTH];
  logic [3:0]  ent_size [DEPTH];

  exp_t           sb_q[$];
  logic [PTR_W:0] exp_head;
  int             tests_run = 0;
  int             tests_failed = 0;

  assign head_addr    = ent_addr[head_ptr[PTR_W-1:0]];
  assign head_data    = ent_data[head_ptr[PTR_W-1:0]];
  assign head_mask    = ent_mask[head_ptr[PTR_W-1:0]];
  assign head_ls_size = ent_size[head_ptr[PTR_W-1:0]];

  sq_deq_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .entry_ready_vec(entry_ready_vec),
    .entry_mmio_vec (entry_mmio_vec),
    .head_addr      (head_addr),
    .head_data      (head_data),
    .head_mask      (head_mask),
    .head_ls_size   (head_ls_size),
    .head_ptr       (head_ptr),
    .issuing_vec    (issuing_vec),
    .dc_req_valid   (dc_req_valid),
    .dc_req_ready   (dc_req_ready),
    .dc_req_addr    (dc_req_addr),
    .dc_req_data    (dc_req_data),
    .dc_req_mask    (dc_req_mask),
    .dc_req_size    (dc_req_size),
    .dc_resp_valid  (dc_resp_valid),
    .mmio_req_valid (mmio_req_valid),
    .mmio_req_ready (mmio_req_ready),
    .mmio_resp_valid(mmio_resp_valid),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ready(input bit mmio, input bit v);
    if (mmio) mmio_req_ready = v;
    else      dc_req_ready   = v;
  endtask

  task automatic do_store(input int mode, input bit mmio, input int ready_delay,
                          input int resp_delay, input logic [63:0] addr);
    exp_t             e;
    int               idx;
    int               waited;
    logic [DEPTH-1:0] one_hot;
    idx = int'(exp_head[PTR_W-1:0]);
    e.addr = addr;
    e.data = {$urandom, $urandom};
    e.mask = {$urandom, $urandom};
    e.size = 4'($urandom_range(0, 15));
    e.mmio = mmio;
    e.idx  = idx;
    ent_addr[idx] = e.addr;
    ent_data[idx] = e.data;
    ent_mask[idx] = e.mask;
    ent_size[idx] = e.size;
    entry_mmio_vec[idx]  = mmio;
    entry_ready_vec[idx] = 1'b1;
    sb_q.push_back(e);
    set_ready(mmio, ready_delay == 0);
    set_ready(!mmio, 1'b0);

    waited = 0;
    @(negedge clock);
    while (!(mmio ? mmio_req_valid : dc_req_valid) && waited < 8) begin
      waited++;
      @(negedge clock);
    end
    check_val("req_start", 64'(mmio ? mmio_req_valid : dc_req_valid), 64'(1));
    if (waited >= 8) begin
      entry_ready_vec = '0;
      void'(sb_q.pop_front());
      return;
    end

    // Request phase: valid and payload must hold until ready.
    for (int k = 0; k <= ready_delay; k++) begin
      check_val("req_valid", 64'(mmio ? mmio_req_valid : dc_req_valid), 64'(1));
      check_val("other_valid", 64'(mmio ? dc_req_valid : mmio_req_valid), 64'(0));
      check_val("req_addr", dc_req_addr, sb_q[0].addr);
      check_val("req_data", dc_req_data, sb_q[0].data);
      check_val("req_mask", dc_req_mask, sb_q[0].mask);
      check_val("req_size", 64'(dc_req_size), 64'(sb_q[0].size));
      if (k == ready_delay) break;
      if (mode == 5) begin
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_dc_valid", 64'(dc_req_valid), 64'(0));
        check_val("rst_mmio_valid", 64'(mmio_req_valid), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_head", 64'(head_ptr), 64'(0));
        check_val("rst_addr", dc_req_addr, 64'(0));
        entry_ready_vec = '0;
        set_ready(mmio, 1'b0);
        void'(sb_q.pop_front());
        exp_head = '0;
        $display("[TB] txn idx=%0d mmio=%0d abandoned by reset", idx, mmio);
        step();
        reset_n = 1'b1;
        step();
        return;
      end
      if (mode == 3) begin
        step();
        flush = 1'b1;
        entry_ready_vec = '0;
        @(negedge clock);
        check_val("flreq_issue", 64'(issuing_vec), 64'(0));
        step();
        flush = 1'b0;
        set_ready(mmio, 1'b0);
        exp_head = '0;
        @(negedge clock);
        check_val("flreq_busy", 64'(busy), 64'(0));
        check_val("flreq_valid", 64'(dc_req_valid | mmio_req_valid), 64'(0));
        check_val("flreq_head", 64'(head_ptr), 64'(exp_head));
        void'(sb_q.pop_front());
        $display("[TB] txn idx=%0d mmio=%0d abandoned by flush", idx, mmio);
        return;
      end
      step();
      if (k + 1 == ready_delay) set_ready(mmio, 1'b1);
      @(negedge clock);
    end

    // Handshake happens at the coming edge.
    e = sb_q.pop_front();
    $display("[TB] txn idx=%0d mmio=%0d addr=0x%h size=%0d mode=%0d", e.idx, e.mmio, e.addr, e.size, mode);
    if (mode == 4) flush = 1'b1;
    step();
    set_ready(mmio, 1'b0);
    flush = 1'b0;
    entry_ready_vec = '0;
    if (mode == 1) flush = 1'b1;
    // While draining, a ready head entry must not start a request.
    if (mode == 4) entry_ready_vec[0] = 1'b1;
    // A response of the other kind must be ignored.
    if (mode == 0 && resp_delay > 0) begin
      if (mmio) dc_resp_valid = 1'b1;
      else      mmio_resp_valid = 1'b1;
    end
    for (int r = 0; r < resp_delay; r++) begin
      @(negedge clock);
      check_val("wait_issue", 64'(issuing_vec), 64'(0));
      check_val("wait_valid", 64'(dc_req_valid | mmio_req_valid), 64'(0));
      check_val("wait_busy", 64'(busy), 64'(1));
      step();
      dc_resp_valid   = 1'b0;
      mmio_resp_valid = 1'b0;
      flush = (mode == 1 && r == 0);
      if (mode == 1) entry_ready_vec[0] = 1'b1;
    end

    if (mode == 2) flush = 1'b1;
    if (mmio) mmio_resp_valid = 1'b1;
    else      dc_resp_valid = 1'b1;
    one_hot = '0;
    one_hot[idx] = 1'b1;
    @(negedge clock);
    check_val("resp_issue", 64'(issuing_vec), 64'((mode == 0) ? one_hot : '0));
    step();
    dc_resp_valid   = 1'b0;
    mmio_resp_valid = 1'b0;
    flush = 1'b0;
    entry_ready_vec = '0;
    if (mode == 0) exp_head = exp_head + (PTR_W+1)'(1);
    else           exp_head = '0;
    @(negedge clock);
    check_val("done_busy", 64'(busy), 64'(0));
    check_val("done_issue", 64'(issuing_vec), 64'(0));
    check_val("head_ptr", 64'(head_ptr), 64'(exp_head));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = '0;
      ent_data[i] = '0;
      ent_mask[i] = '0;
      ent_size[i] = '0;
    end
    exp_head = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("reset_head", 64'(head_ptr), 64'(0));
    check_val("reset_issue", 64'(issuing_vec), 64'(0));
    check_val("reset_dc_valid", 64'(dc_req_valid), 64'(0));
    check_val("reset_mmio_valid", 64'(mmio_req_valid), 64'(0));
    check_val("reset_busy", 64'(busy), 64'(0));
    check_val("reset_addr", dc_req_addr, 64'(0));
    check_val("reset_size", 64'(dc_req_size), 64'(0));
    step();
    reset_n = 1'b1;
    step();

    do_store(0, 1'b0, 0, 2, 64'h8000_1000);
    do_store(0, 1'b0, 3, 1, {$urandom, $urandom});
    do_store(0, 1'b1, 0, 2, {$urandom, $urandom});
    // Two full laps past the 7 -> 8 and 15 -> 0 wrap points.
    for (int i = 0; i < 18; i++) begin
      do_store(0, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 3),
               {$urandom, $urandom});
    end

    do_store(1, 1'b0, 0, 4, {$urandom, $urandom});
    do_store(0, 1'b0, 0, 1, {$urandom, $urandom});
    do_store(2, 1'b0, 1, 2, {$urandom, $urandom});
    do_store(1, 1'b1, 0, 3, {$urandom, $urandom});
    do_store(0, 1'b1, 1, 1, {$urandom, $urandom});
    do_store(3, 1'b0, 2, 1, {$urandom, $urandom});
    do_store(4, 1'b1, 1, 2, {$urandom, $urandom});
    do_store(0, 1'b0, 0, 1, {$urandom, $urandom});

    // Responses while idle are ignored.
    step();
    dc_resp_valid   = 1'b1;
    mmio_resp_valid = 1'b1;
    @(negedge clock);
    check_val("idle_resp_issue", 64'(issuing_vec), 64'(0));
    step();
    dc_resp_valid   = 1'b0;
    mmio_resp_valid = 1'b0;
    @(negedge clock);
    check_val("idle_resp_head", 64'(head_ptr), 64'(exp_head));
    check_val("idle_resp_busy", 64'(busy), 64'(0));

    do_store(5, 1'b0, 2, 1, {$urandom, $urandom});
    do_store(0, 1'b0, 1, 2, {$urandom, $urandom});
    do_store(0, 1'b1, 0, 1, {$urandom, $urandom});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
